// File: rtl/ipf_seq_if.sv
// ipf_seq_if -- bundle of the upstream handshakes and the IPF command bus
// driven by the ipf_seq sequencer.
//
// Signals:
//   src_i_valid/src_i_data/src_i_ready : upstream 8-bit input byte stream
//   src_w_valid/src_w_data/src_w_ready : upstream 4-bit weight stream
//   ipf_i_valid/ipf_i_data             : input strobe and byte towards the IPF
//   ipf_w_valid/ipf_w_data             : weight strobe and nibble towards the IPF
//   ipf_ctrl                           : IPF command (0=END,1=LOAD_W,2=COMPUTE,3=NOP)
//   ipf_finish                         : IPF reports frame complete
//
// Modports:
//   master : the sequencer (accepts upstream data, drives the IPF)
//   slave  : the environment (upstream sources plus the IPF)
interface ipf_seq_if;
  logic       src_i_valid;
  logic [7:0] src_i_data;
  logic       src_i_ready;
  logic       src_w_valid;
  logic [3:0] src_w_data;
  logic       src_w_ready;
  logic       ipf_i_valid;
  logic [7:0] ipf_i_data;
  logic       ipf_w_valid;
  logic [3:0] ipf_w_data;
  logic [2:0] ipf_ctrl;
  logic       ipf_finish;

  modport master (
    input  src_i_valid, src_i_data, src_w_valid, src_w_data, ipf_finish,
    output src_i_ready, src_w_ready, ipf_i_valid, ipf_i_data,
           ipf_w_valid, ipf_w_data, ipf_ctrl
  );

  modport slave (
    output src_i_valid, src_i_data, src_w_valid, src_w_data, ipf_finish,
    input  src_i_ready, src_w_ready, ipf_i_valid, ipf_i_data,
           ipf_w_valid, ipf_w_data, ipf_ctrl
  );
endinterface

// File: rtl/ipf_seq.sv
// ipf_seq -- frame sequencer for an IPF engine.
// A frame is N_GROUP groups; each group streams I_PER_GROUP input bytes and
// then runs two weight phases (LOAD_W, CMP_WAIT NOP cycles, COMPUTE). After
// the last group an END command is issued and the sequencer drains until the
// IPF reports ipf_finish, then pulses done.
//
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous, active-high reset
//   start : one-cycle frame start pulse (honoured only when idle)
//   bus   : ipf_seq_if.master (upstream handshakes and IPF command bus)
//   busy  : frame in progress
//   done  : one-cycle pulse at frame completion
//   err   : drain watchdog expired, sticky until the next start
//
// Configuration:
//   IPF_SEQ_TIMEOUT_EN : when defined, DRAIN is bounded by a TIMEOUT-cycle
//   watchdog; when undefined DRAIN waits indefinitely and err is tied low.
//
// All IPF outputs, ready, busy and done are registered: they show the state
// and transfer of the previous cycle.
module ipf_seq #(
  parameter int N_GROUP     = 2,
  parameter int I_PER_GROUP = 3,
  parameter int CMP_WAIT    = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  ipf_seq_if.master bus,
  output logic      busy,
  output logic      done,
  output logic      err
);

  localparam logic [2:0] CTRL_END     = 3'd0;
  localparam logic [2:0] CTRL_LOAD_W  = 3'd1;
  localparam logic [2:0] CTRL_COMPUTE = 3'd2;
  localparam logic [2:0] CTRL_NOP     = 3'd3;

  localparam int IW = (I_PER_GROUP > 1) ? $clog2(I_PER_GROUP) : 1;
  localparam int WW = (CMP_WAIT > 1) ? $clog2(CMP_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_I  = 3'd1,
    S_LD_W  = 3'd2,
    S_WAIT  = 3'd3,
    S_CMP   = 3'd4,
    S_END   = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t         state;
  logic [3:0]     grp;
  logic           phase;
  logic [IW-1:0]  i_cnt;
  logic [WW-1:0]  w_cnt;

  if (N_GROUP < 1 || N_GROUP > 15 || I_PER_GROUP < 1 || CMP_WAIT < 0 || TIMEOUT < 1)
  begin : g_bad_param
    $error("ipf_seq: parameter out of range");
  end

`ifdef IPF_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] to_cnt;
`else
  assign err = 1'b0;
`endif

  // Frame FSM: next state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      grp             <= 4'd0;
      phase           <= 1'b0;
      i_cnt           <= {IW{1'b0}};
      w_cnt           <= {WW{1'b0}};
      bus.src_i_ready <= 1'b0;
      bus.src_w_ready <= 1'b0;
      bus.ipf_i_valid <= 1'b0;
      bus.ipf_i_data  <= 8'h00;
      bus.ipf_w_valid <= 1'b0;
      bus.ipf_w_data  <= 4'h0;
      bus.ipf_ctrl    <= CTRL_NOP;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef IPF_SEQ_TIMEOUT_EN
      to_cnt          <= {TW{1'b0}};
      err             <= 1'b0;
`endif
    end else begin
      // Strobes last one cycle; the command bus idles at NOP.
      bus.ipf_i_valid <= 1'b0;
      bus.ipf_w_valid <= 1'b0;
      bus.ipf_ctrl    <= CTRL_NOP;
      done            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_LD_I;
            grp             <= 4'd0;
            phase           <= 1'b0;
            i_cnt           <= {IW{1'b0}};
            busy            <= 1'b1;
            bus.src_i_ready <= 1'b1;
`ifdef IPF_SEQ_TIMEOUT_EN
            err             <= 1'b0;
`endif
          end
        end

        S_LD_I: begin
          if (bus.src_i_valid && bus.src_i_ready) begin
            bus.ipf_i_valid <= 1'b1;
            bus.ipf_i_data  <= bus.src_i_data;
            if (i_cnt == IW'(I_PER_GROUP - 1)) begin
              // i_cnt wraps to zero so the next group starts clean.
              i_cnt           <= {IW{1'b0}};
              state           <= S_LD_W;
              bus.src_i_ready <= 1'b0;
              bus.src_w_ready <= 1'b1;
            end else begin
              i_cnt <= i_cnt + IW'(1);
            end
          end
        end

        S_LD_W: begin
          if (bus.src_w_valid && bus.src_w_ready) begin
            bus.ipf_w_valid <= 1'b1;
            bus.ipf_w_data  <= bus.src_w_data;
            bus.ipf_ctrl    <= CTRL_LOAD_W;
            bus.src_w_ready <= 1'b0;
            w_cnt           <= {WW{1'b0}};
            state           <= (CMP_WAIT == 0) ? S_CMP : S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_cnt == WW'(CMP_WAIT - 1)) begin
            state <= S_CMP;
          end else begin
            w_cnt <= w_cnt + WW'(1);
          end
        end

        S_CMP: begin
          bus.ipf_ctrl <= CTRL_COMPUTE;
          if (phase == 1'b0) begin
            phase           <= 1'b1;
            state           <= S_LD_W;
            bus.src_w_ready <= 1'b1;
          end else begin
            phase <= 1'b0;
            grp   <= grp + 4'd1;
            if (grp == 4'(N_GROUP - 1)) begin
              state <= S_END;
            end else begin
              state           <= S_LD_I;
              bus.src_i_ready <= 1'b1;
            end
          end
        end

        S_END: begin
          bus.ipf_ctrl <= CTRL_END;
          state        <= S_DRAIN;
`ifdef IPF_SEQ_TIMEOUT_EN
          to_cnt       <= {TW{1'b0}};
`endif
        end

        S_DRAIN: begin
          // ipf_finish is only looked at here; a finish seen earlier is ignored.
          if (bus.ipf_finish) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef IPF_SEQ_TIMEOUT_EN
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
`endif
          end
        end

        default: begin
          state           <= S_IDLE;
          busy            <= 1'b0;
          bus.src_i_ready <= 1'b0;
          bus.src_w_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ipf_seq.md
IPF_SEQ -- requirements
Module: ipf_seq

Interface
REQ-001 Parameter: N_GROUP, default 2, number of input groups per frame (1..15).
REQ-002 Parameter: I_PER_GROUP, default 3, input beats per group.
REQ-003 Parameter: CMP_WAIT, default 2, NOP cycles between weight load and compute strobe.
REQ-004 Parameter: TIMEOUT, default 1024, drain watchdog limit in cycles.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start pulse.
- src_i_valid  in  1  upstream input byte valid.
- src_i_data  in  8  upstream input byte.
- src_i_ready  out  1  sequencer accepts input byte.
- src_w_valid  in  1  upstream weight valid.
- src_w_data  in  4  upstream weight.
- src_w_ready  out  1  sequencer accepts weight.
- ipf_i_valid  out  1  IPF input strobe.
- ipf_i_data  out  8  IPF input data.
- ipf_w_valid  out  1  IPF weight strobe.
- ipf_w_data  out  4  IPF weight data.
- ipf_ctrl  out  3  IPF command: 0=END, 1=LOAD_W, 2=COMPUTE, 3=NOP.
- ipf_finish  in  1  IPF frame complete.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  watchdog error, sticky until next start.
REQ-006 Clock is clk; reset is rst, synchronous and active-high; one clock domain.

Function
REQ-007 States: IDLE, LD_I, LD_W, WAIT, CMP, END, DRAIN; all ipf_* outputs and done are registered and reflect the state/transfer of the previous cycle.
REQ-008 IDLE: start=1 -> LD_I, group counter=0, weight phase=0, err cleared; start in any other state is ignored.
REQ-009 LD_I: src_i_ready=1; each src_i_valid&src_i_ready beat drives ipf_i_valid=1, ipf_i_data=src_i_data next cycle; after I_PER_GROUP beats -> LD_W.
REQ-010 LD_W: src_w_ready=1; on accepted weight, next cycle ipf_w_valid=1, ipf_w_data=src_w_data, ipf_ctrl=1; then -> WAIT.
REQ-011 WAIT: ipf_ctrl=3 for exactly CMP_WAIT cycles -> CMP.
REQ-012 CMP: ipf_ctrl=2 for one cycle; phase 0 -> phase=1, LD_W; phase 1 -> group+1, phase=0, LD_I if group<N_GROUP-1, else END.
REQ-013 Upstream stall (valid low in LD_I/LD_W): no transfer, ipf_i_valid=ipf_w_valid=0, ipf_ctrl=3, state held.
REQ-014 END: ipf_ctrl=0 one cycle -> DRAIN; DRAIN: ipf_ctrl=3 until ipf_finish=1 -> IDLE with done=1 for one cycle.
REQ-015 ipf_finish outside DRAIN is ignored.
REQ-016 busy=1 in every state except IDLE; src_*_ready=0 outside LD_I/LD_W.
REQ-017 Per frame exactly N_GROUP*I_PER_GROUP input strobes, 2*N_GROUP weight strobes, 2*N_GROUP COMPUTE, one END.

Reset
REQ-018 rst=1 at a clock edge forces IDLE, counters 0; next cycle: all valid/ready/busy/done/err=0, ipf_i_data=0, ipf_w_data=0, ipf_ctrl=3.
REQ-019 Reset mid-frame abandons the frame; no END or done issued; next start begins a fresh frame.

Configuration
REQ-020 Macro IPF_SEQ_TIMEOUT_EN defined: DRAIN counts cycles; at TIMEOUT cycles without ipf_finish -> IDLE, err=1 (sticky), done not pulsed.
REQ-021 Macro IPF_SEQ_TIMEOUT_EN undefined: no counter, DRAIN waits indefinitely, err tied 0.

Verification
REQ-022 Defaults, upstream always valid, bytes 0x11..0x16, weights 0x3/0xA repeated; start -> ctrl trace per group: 3 i-strobes, 1, 3, 3, 2, 1, 3, 3, 2; then 0; finish -> done pulse.
REQ-023 src_i_valid low 4 cycles mid-LD_I -> ipf_i_valid gaps match, byte order/count unchanged (6 total).
REQ-024 start pulsed again during CMP -> ignored, trace identical to REQ-022.
REQ-025 rst asserted during second WAIT -> next cycle busy=0, ctrl=3; new start -> full correct frame.
REQ-026 With IPF_SEQ_TIMEOUT_EN, TIMEOUT=16, finish never asserted -> err=1 exactly 16 cycles after DRAIN entry, busy=0, no done.
REQ-027 ipf_finish pulsed during LD_W -> ignored, frame completes per REQ-022.
